// File: rtl/decompress_unpack.sv
// Unpacks 64-bit LE words into 4 x 12-bit zero-extended coefficients (d = 1/5/11/12); optional ABR_UNPACK_RANGE_CHK_EN adds sticky range_err_o.
// Latency: word accepted at cycle n yields valid_o at n+1; input stalls (ready_o=0) once fill > 64, output holds while !ready_i.
package abr_params_pkg;
    localparam int MLKEM_Q_WIDTH = 12;
    localparam int MLKEM_Q       = 3329;
    typedef enum logic [1:0] {
        DECOMPRESS1      = 2'd0,
        DECOMPRESS5      = 2'd1,
        DECOMPRESS11     = 2'd2,
        DECOMPRESS_RAW12 = 2'd3
    } decompress_mode_t;
endpackage

module decompress_unpack
    import abr_params_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int LANES = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           zeroize,
    input  logic                           start_i,
    input  decompress_mode_t               mode_i,
    input  logic [IN_W-1:0]                data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [LANES*MLKEM_Q_WIDTH-1:0] coef_o,
    output decompress_mode_t               mode_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           busy_o,
    output logic                           done_o
`ifdef ABR_UNPACK_RANGE_CHK_EN
    ,
    output logic                           range_err_o
`endif
);
    localparam int N_COEF = 256;
    localparam int BUF_W  = 2 * IN_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int WCNT_W = $clog2(MLKEM_Q_WIDTH * N_COEF / IN_W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic [5:0]        r_grp;
    logic [WCNT_W-1:0] r_words;
    decompress_mode_t  r_mode;

    logic [FILL_W-1:0] w_d;
    logic [FILL_W-1:0] w_gbits;
    logic [WCNT_W-1:0] w_wmax;
    logic              w_in;
    logic              w_out;
    logic [BUF_W-1:0]  w_shifted;
    logic [BUF_W-1:0]  w_buf_nxt;
    logic [FILL_W-1:0] w_base;
    logic [FILL_W-1:0] w_fill_nxt;

    always_comb begin
        case (r_mode)
            DECOMPRESS1:  w_d = FILL_W'(1);
            DECOMPRESS5:  w_d = FILL_W'(5);
            DECOMPRESS11: w_d = FILL_W'(11);
            default:      w_d = FILL_W'(12);
        endcase
    end

    // A polynomial is exactly 256*d bits, so the word budget leaves no residue.
    assign w_gbits = FILL_W'(LANES) * w_d;
    assign w_wmax  = WCNT_W'((int'(w_d) * N_COEF) / IN_W);

    assign ready_o = (r_state == ST_RUN) && (r_fill <= FILL_W'(IN_W)) && (r_words < w_wmax);
    assign valid_o = (r_state == ST_RUN) && (r_fill >= w_gbits);
    assign w_in    = valid_i && ready_o;
    assign w_out   = valid_o && ready_i;

    // Shift out the consumed group first, then append the new word above what remains.
    assign w_shifted  = w_out ? (r_buf >> w_gbits) : r_buf;
    assign w_base     = r_fill - (w_out ? w_gbits : '0);
    assign w_buf_nxt  = w_in ? (w_shifted | ({{IN_W{1'b0}}, data_i} << w_base)) : w_shifted;
    assign w_fill_nxt = w_base + (w_in ? FILL_W'(IN_W) : '0);

    always_comb begin
        coef_o = '0;
        for (int k = 0; k < LANES; k++) begin
            case (r_mode)
                DECOMPRESS1:  coef_o[k*MLKEM_Q_WIDTH +: MLKEM_Q_WIDTH] = {{(MLKEM_Q_WIDTH-1){1'b0}}, r_buf[k]};
                DECOMPRESS5:  coef_o[k*MLKEM_Q_WIDTH +: MLKEM_Q_WIDTH] = {{(MLKEM_Q_WIDTH-5){1'b0}}, r_buf[k*5 +: 5]};
                DECOMPRESS11: coef_o[k*MLKEM_Q_WIDTH +: MLKEM_Q_WIDTH] = {{(MLKEM_Q_WIDTH-11){1'b0}}, r_buf[k*11 +: 11]};
                default:      coef_o[k*MLKEM_Q_WIDTH +: MLKEM_Q_WIDTH] = r_buf[k*MLKEM_Q_WIDTH +: MLKEM_Q_WIDTH];
            endcase
        end
    end

    assign mode_o = r_mode;
    assign busy_o = (r_state == ST_RUN);
    assign done_o = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_fill  <= '0;
            r_grp   <= '0;
            r_words <= '0;
            r_mode  <= DECOMPRESS1;
        end else if (zeroize) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_fill  <= '0;
            r_grp   <= '0;
            r_words <= '0;
            r_mode  <= DECOMPRESS1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode_i;
                        r_buf   <= '0;
                        r_fill  <= '0;
                        r_grp   <= '0;
                        r_words <= '0;
                    end
                end
                ST_RUN: begin
                    r_buf  <= w_buf_nxt;
                    r_fill <= w_fill_nxt;
                    if (w_in) r_words <= r_words + WCNT_W'(1);
                    if (w_out) begin
                        r_grp <= r_grp + 6'd1;
                        if (r_grp == 6'd63) r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ABR_UNPACK_RANGE_CHK_EN
    logic w_lane_hi;
    logic r_range_err;

    always_comb begin
        w_lane_hi = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (r_buf[k*MLKEM_Q_WIDTH +: MLKEM_Q_WIDTH] >= MLKEM_Q_WIDTH'(MLKEM_Q)) w_lane_hi = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_range_err <= 1'b0;
        end else if (zeroize) begin
            r_range_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start_i) begin
            r_range_err <= 1'b0;
        end else if (w_out && (r_mode == DECOMPRESS_RAW12) && w_lane_hi) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err_o = r_range_err;
`endif
endmodule

// File: tb/tb_decompress_unpack.sv
// Randomised bench for decompress_unpack: coefficient-level model packs polynomials into words and predicts groups, fill and handshakes.
module tb_decompress_unpack;
    import abr_params_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             zeroize = 1'b0;
    logic             start_i = 1'b0;
    decompress_mode_t mode_i = DECOMPRESS1;
    logic [63:0]      data_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [47:0]      coef_o;
    decompress_mode_t mode_o;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic             busy_o;
    logic             done_o;
`ifdef ABR_UNPACK_RANGE_CHK_EN
    logic             range_err_o;
`endif

    decompress_unpack dut (
        .clk     (clk),
        .reset_n (reset_n),
        .zeroize (zeroize),
        .start_i (start_i),
        .mode_i  (mode_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .coef_o  (coef_o),
        .mode_o  (mode_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .done_o  (done_o)
`ifdef ABR_UNPACK_RANGE_CHK_EN
        ,
        .range_err_o (range_err_o)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] words [48];
    logic [11:0] exp_c [256];
    logic [11:0] got_c [256];

    function automatic int d_of(input decompress_mode_t m);
        case (m)
            DECOMPRESS1:  return 1;
            DECOMPRESS5:  return 5;
            DECOMPRESS11: return 11;
            default:      return 12;
        endcase
    endfunction

    task automatic pack_coefs(input int d);
        int pos;
        for (int w = 0; w < 48; w++) words[w] = '0;
        for (int i = 0; i < 256; i++)
            for (int b = 0; b < d; b++) begin
                pos = i * d + b;
                words[pos / 64][pos % 64] = exp_c[i][b];
            end
    endtask

    task automatic unpack_words(input int d);
        int pos;
        for (int i = 0; i < 256; i++) begin
            exp_c[i] = '0;
            for (int b = 0; b < d; b++) begin
                pos = i * d + b;
                exp_c[i][b] = words[pos / 64][pos % 64];
            end
        end
    endtask

    task automatic start_poly(input decompress_mode_t m);
        @(posedge clk); #1;
        start_i = 1'b1;
        mode_i  = m;
        @(posedge clk); #1;
        start_i = 1'b0;
        mode_i  = decompress_mode_t'(2'($urandom));
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL start_ready got %b exp 1", ready_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", busy_o); end
        checks++; if (mode_o !== m) begin errors++; $display("FAIL start_mode got %0d exp %0d", mode_o, m); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL start_valid got %b exp 0", valid_o); end
    endtask

    task automatic run_poly(input decompress_mode_t m, input int vld_pct, input int rdy_pct, input int stop_after);
        int d, gb, wmax, win, gout, fill, cyc;
        bit acc_in, acc_out, prev_stall, exp_err, hi;
        logic [47:0] prev_coef;
        d = d_of(m); gb = 4 * d; wmax = 4 * d;
        win = 0; gout = 0; fill = 0; cyc = 0;
        prev_stall = 0; exp_err = 0; prev_coef = '0;
        while (gout < stop_after && cyc < 3000) begin
            valid_i = (win < wmax) && ($urandom_range(99) < vld_pct);
            data_i  = valid_i ? words[win] : {$urandom, $urandom};
            ready_i = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            checks++;
            if (ready_o !== ((fill <= 64) && (win < wmax))) begin
                errors++; $display("FAIL ready_o got %b fill %0d words %0d", ready_o, fill, win);
            end
            checks++;
            if (valid_o !== (fill >= gb)) begin
                errors++; $display("FAIL valid_o got %b fill %0d grp %0d", valid_o, fill, gout);
            end
            if (prev_stall) begin
                checks++;
                if (coef_o !== prev_coef) begin
                    errors++; $display("FAIL stall_stable got %h exp %h", coef_o, prev_coef);
                end
            end
            if (fill >= gb)
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (coef_o[12*k +: 12] !== exp_c[4*gout+k]) begin
                        errors++; $display("FAIL lane grp %0d lane %0d got %0d exp %0d", gout, k, coef_o[12*k +: 12], exp_c[4*gout+k]);
                    end
                end
`ifdef ABR_UNPACK_RANGE_CHK_EN
            checks++;
            if (range_err_o !== exp_err) begin
                errors++; $display("FAIL range_err grp %0d got %b exp %b", gout, range_err_o, exp_err);
            end
`endif
            acc_in  = valid_i && (fill <= 64) && (win < wmax);
            acc_out = ready_i && (fill >= gb);
            if (acc_out) begin
                hi = 0;
                for (int k = 0; k < 4; k++) begin
                    got_c[4*gout+k] = coef_o[12*k +: 12];
                    if (exp_c[4*gout+k] >= 12'd3329) hi = 1;
                end
                if (hi && m == DECOMPRESS_RAW12) exp_err = 1;
                gout++;
            end
            prev_stall = (fill >= gb) && !ready_i;
            prev_coef  = coef_o;
            fill = fill - (acc_out ? gb : 0) + (acc_in ? 64 : 0);
            if (acc_in) win++;
            cyc++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        if (gout < stop_after) begin
            checks++; errors++;
            $display("FAIL timeout groups got %0d exp %0d", gout, stop_after);
        end
        if (stop_after == 64) begin
            @(negedge clk);
            checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL done_pulse got %b exp 1", done_o); end
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_fall got %b exp 0", busy_o); end
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL done_valid got %b exp 0", valid_o); end
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL done_ready got %b exp 0", ready_o); end
`ifdef ABR_UNPACK_RANGE_CHK_EN
            checks++; if (range_err_o !== exp_err) begin errors++; $display("FAIL range_err_end got %b exp %b", range_err_o, exp_err); end
`endif
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", done_o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_o); end
        checks++; if (coef_o !== 48'd0) begin errors++; $display("FAIL rst_coef got %h exp 0", coef_o); end
        checks++; if (mode_o !== DECOMPRESS1) begin errors++; $display("FAIL rst_mode got %0d exp 0", mode_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done_o); end
        reset_n = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        data_i  = {$urandom, $urandom};
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", valid_o); end
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_d1();
        logic [11:0] e;
        words[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        words[1] = 64'h0;
        words[2] = 64'hAAAA_AAAA_AAAA_AAAA;
        words[3] = 64'h5555_5555_5555_5555;
        unpack_words(1);
        start_poly(DECOMPRESS1);
        run_poly(DECOMPRESS1, 100, 100, 64);
        for (int g = 0; g < 64; g += 16)
            for (int k = 0; k < 4; k++) begin
                e = (g == 0) ? 12'd1 : (g == 16) ? 12'd0 : (g == 32) ? 12'(k % 2) : 12'((k + 1) % 2);
                checks++;
                if (got_c[4*g+k] !== e) begin errors++; $display("FAIL d1_pattern grp %0d lane %0d got %0d exp %0d", g, k, got_c[4*g+k], e); end
            end
    endtask

    task automatic test_d11();
        for (int i = 0; i < 256; i++) exp_c[i] = 12'(i);
        pack_coefs(11);
        start_poly(DECOMPRESS11);
        run_poly(DECOMPRESS11, 100, 100, 64);
        checks++; if (got_c[5] !== 12'd5) begin errors++; $display("FAIL d11_straddle got %0d exp 5", got_c[5]); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_c[40+k] !== 12'(40 + k)) begin errors++; $display("FAIL d11_grp10 lane %0d got %0d exp %0d", k, got_c[40+k], 40 + k); end
        end
    endtask

    task automatic test_d12_random();
        for (int i = 0; i < 256; i++) exp_c[i] = 12'($urandom_range(3328));
        pack_coefs(12);
        start_poly(DECOMPRESS_RAW12);
        run_poly(DECOMPRESS_RAW12, 60, 30, 64);
    endtask

    task automatic test_d5_streaming();
        for (int i = 0; i < 256; i++) exp_c[i] = 12'($urandom_range(31));
        pack_coefs(5);
        start_poly(DECOMPRESS5);
        run_poly(DECOMPRESS5, 100, 100, 64);
    endtask

    task automatic test_zeroize();
        for (int i = 0; i < 256; i++) exp_c[i] = 12'($urandom_range(2047));
        pack_coefs(11);
        start_poly(DECOMPRESS11);
        run_poly(DECOMPRESS11, 80, 80, 5);
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL zero_ready got %b exp 0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL zero_valid got %b exp 0", valid_o); end
        checks++; if (coef_o !== 48'd0) begin errors++; $display("FAIL zero_coef got %h exp 0", coef_o); end
        checks++; if (mode_o !== DECOMPRESS1) begin errors++; $display("FAIL zero_mode got %0d exp 0", mode_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_done got %b exp 0", done_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 256; i++) exp_c[i] = 12'($urandom_range(31));
        pack_coefs(5);
        start_poly(DECOMPRESS5);
        run_poly(DECOMPRESS5, 90, 90, 10);
        reset_n = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", valid_o); end
        checks++; if (coef_o !== 48'd0) begin errors++; $display("FAIL mid_rst_coef got %h exp 0", coef_o); end
        checks++; if (mode_o !== DECOMPRESS1) begin errors++; $display("FAIL mid_rst_mode got %0d exp 0", mode_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy_o); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mid_rst_nodone cyc %0d got %b exp 0", c, done_o); end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) exp_c[i] = 12'($urandom_range(31));
        pack_coefs(5);
        start_poly(DECOMPRESS5);
        run_poly(DECOMPRESS5, 90, 90, 64);
    endtask

`ifdef ABR_UNPACK_RANGE_CHK_EN
    task automatic test_range();
        for (int i = 0; i < 256; i++) exp_c[i] = 12'($urandom_range(3328));
        exp_c[7] = 12'd3329;
        pack_coefs(12);
        start_poly(DECOMPRESS_RAW12);
        run_poly(DECOMPRESS_RAW12, 100, 70, 64);
        checks++; if (range_err_o !== 1'b1) begin errors++; $display("FAIL range_hold got %b exp 1", range_err_o); end
        start_poly(DECOMPRESS_RAW12);
        checks++; if (range_err_o !== 1'b0) begin errors++; $display("FAIL range_clear got %b exp 0", range_err_o); end
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_d1();
        test_d11();
        test_d12_random();
        test_d5_streaming();
        test_zeroize();
        test_reset_mid();
`ifdef ABR_UNPACK_RANGE_CHK_EN
        test_range();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
